// File: rtl/event_capture_fifo_if.sv
// Event handshake bundle between the capture front end and the filter stage.
// Handshake: the source holds ev_valid, ev_chan and ev_ts steady until the
// sink samples ev_ready=1 on the same rising edge. ev_valid never waits on
// ev_ready, and the transfer completes only when ev_valid & ev_ready are both
// high at a rising clk edge.
interface event_capture_fifo_if #(
   parameter int CH_W     = 3,
   parameter int TS_WIDTH = 8
);
   logic                ev_valid;
   logic                ev_ready;
   logic [CH_W-1:0]     ev_chan;
   logic [TS_WIDTH-1:0] ev_ts;

   modport master (output ev_valid, output ev_chan, output ev_ts, input ev_ready);
   modport slave  (input ev_valid, input ev_chan, input ev_ts, output ev_ready);
endinterface

// File: rtl/event_capture_fifo.sv
// event_capture_fifo: synchronises raw event pins, detects rising edges,
// holds them in per-channel pending bits, and queues them lowest-channel-first
// as {channel, timestamp} into a first-word-fall-through FIFO.
// Optional feature macro: EVCAP_DROP_CNT_EN enables the saturating 8-bit
// dropped-event counter; without it drop_cnt is tied to zero.
module event_capture_fifo #(
   parameter int NUM_CH     = 8,
   parameter int CH_W       = 3,
   parameter int TS_WIDTH   = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ena,
   input  logic [NUM_CH-1:0]    ev_in,
   event_capture_fifo_if.master ev_if,
   output logic                 overflow,
   output logic [7:0]           drop_cnt
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [NUM_CH-1:0]   sync1, sync2, prev;
   logic [NUM_CH-1:0]   pending;
   logic [NUM_CH-1:0]   edges;
   logic [NUM_CH-1:0]   drops;
   logic [NUM_CH-1:0]   grant;
   logic [CH_W-1:0]     grant_idx;
   logic                grant_any;
   logic [TS_WIDTH-1:0] ts;
   logic [AW-1:0]       wr_ptr, rd_ptr;
   logic [AW:0]         count;
   logic                fifo_full;
   logic                pop;
   logic                push;
   logic [CH_W-1:0]     chan_mem [FIFO_DEPTH];
   logic [TS_WIDTH-1:0] ts_mem   [FIFO_DEPTH];

   // Rising-edge detect on the synchronised pins. Edges arriving while a
   // channel's previous event is still pending are drops; with ena=0 edges
   // are simply lost.
   assign edges = sync2 & ~prev;
   assign drops = edges & pending & {NUM_CH{ena}};

   // FIFO status and handshake. A push may use the slot freed by a pop in
   // the same cycle, so a full FIFO being drained still accepts one entry.
   assign fifo_full      = (count == (AW+1)'(FIFO_DEPTH));
   assign ev_if.ev_valid = (count != '0);
   assign pop            = ev_if.ev_valid & ev_if.ev_ready;
   assign push           = ena & grant_any & (~fifo_full | pop);
   assign ev_if.ev_chan  = ev_if.ev_valid ? chan_mem[rd_ptr] : '0;
   assign ev_if.ev_ts    = ev_if.ev_valid ? ts_mem[rd_ptr]   : '0;

   // Two-flop synchroniser plus previous-value register; runs regardless of ena.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
         prev  <= '0;
      end else begin
         sync1 <= ev_in;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   // Fixed-priority arbiter: lowest-index pending channel wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (pending[i] && !grant_any) begin
            grant[i]  = 1'b1;
            grant_idx = CH_W'(i);
            grant_any = 1'b1;
         end
      end
   end

   // Pending bits: cleared on push, set by a fresh edge when ena=1. An edge
   // hitting an already-pending channel is counted as a drop and adds nothing.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending <= '0;
      end else begin
         pending <= (pending & ~(grant & {NUM_CH{push}}))
                  | (edges & ~pending & {NUM_CH{ena}});
      end
   end

   // Free-running timestamp, frozen while ena=0, wraps naturally.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ts <= '0;
      end else if (ena) begin
         ts <= ts + 1'b1;
      end
   end

   // FIFO storage; contents need no reset because the outputs are gated by count.
   always_ff @(posedge clk) begin
      if (push) begin
         chan_mem[wr_ptr] <= grant_idx;
         ts_mem[wr_ptr]   <= ts;
      end
   end

   // FIFO pointers and occupancy; pointers wrap modulo the power-of-two depth.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Sticky overflow flag: set by any drop since reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         overflow <= 1'b0;
      end else if (|drops) begin
         overflow <= 1'b1;
      end
   end

`ifdef EVCAP_DROP_CNT_EN
   logic [8:0] drop_add;
   logic [8:0] drop_sum;
   logic [7:0] drop_cnt_q;

   // Several channels can drop in one cycle; add them all and saturate at 255.
   always_comb begin
      drop_add = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         drop_add = drop_add + 9'(drops[i]);
      end
      drop_sum = {1'b0, drop_cnt_q} + drop_add;
   end

   // Saturating dropped-event counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         drop_cnt_q <= '0;
      end else if (drop_sum > 9'd255) begin
         drop_cnt_q <= 8'hff;
      end else begin
         drop_cnt_q <= drop_sum[7:0];
      end
   end

   assign drop_cnt = drop_cnt_q;
`else
   assign drop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_event_capture_fifo.sv
// Self-checking bench for event_capture_fifo: directed scenarios followed by
// randomized pin/ready/ena/reset activity, all checked against a queue-based
// reference model of the event capture rules.
module tb_event_capture_fifo;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ev_in;
   logic       ready;
   logic       overflow;
   logic [7:0] drop_cnt;

   int vectors;
   int miscompares;

`ifdef EVCAP_DROP_CNT_EN
   localparam int CNT_ON = 1;
`else
   localparam int CNT_ON = 0;
`endif

   event_capture_fifo_if #(.CH_W(3), .TS_WIDTH(8)) ev_if ();
   assign ev_if.ev_ready = ready;

   event_capture_fifo #(
      .NUM_CH(8), .CH_W(3), .TS_WIDTH(8), .FIFO_DEPTH(4)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ena      (ena),
      .ev_in    (ev_in),
      .ev_if    (ev_if),
      .overflow (overflow),
      .drop_cnt (drop_cnt)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model state: pin samples 0/1/2 clocks back, pending set,
   // expected FIFO contents {chan, ts}, timestamp, sticky flag, drop total
   logic [7:0]  pin0, pin1, pin2;
   logic [7:0]  m_pend;
   logic [10:0] exp_q[$];
   logic [7:0]  m_ts;
   logic        m_ovf;
   int          m_drops;

   task automatic model_step();
      logic [7:0] rise;
      logic [7:0] new_pend;
      logic       popd;
      int         g;
      if (!rst_n) begin
         pin0 = '0; pin1 = '0; pin2 = '0;
         m_pend = '0; exp_q.delete(); m_ts = '0; m_ovf = 1'b0; m_drops = 0;
         return;
      end
      rise = pin1 & ~pin2;
      popd = (exp_q.size() != 0) && ready;
      g = -1;
      if (ena && (exp_q.size() < 4 || popd)) begin
         for (int i = 0; i < 8; i++) if (m_pend[i] && g < 0) g = i;
      end
      if (ena) begin
         for (int i = 0; i < 8; i++) begin
            if (rise[i] && m_pend[i]) begin
               m_ovf = 1'b1;
               m_drops++;
            end
         end
      end
      if (popd) void'(exp_q.pop_front());
      new_pend = m_pend;
      if (g >= 0) begin
         exp_q.push_back({3'(g), m_ts});
         new_pend[g] = 1'b0;
      end
      if (ena) new_pend = new_pend | (rise & ~m_pend);
      m_pend = new_pend;
      if (ena) m_ts = m_ts + 8'd1;
      pin2 = pin1; pin1 = pin0; pin0 = ev_in;
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // scoreboard: compare every DUT output with the model after each edge
   task automatic check_outputs(string tag);
      logic [10:0] head;
      logic        exp_valid;
      int          exp_dc;
      exp_valid = (exp_q.size() != 0);
      head = exp_valid ? exp_q[0] : 11'd0;
      exp_dc = CNT_ON ? ((m_drops > 255) ? 255 : m_drops) : 0;
      chk({tag, ".valid"},    32'(ev_if.ev_valid), 32'(exp_valid));
      chk({tag, ".chan"},     32'(ev_if.ev_chan),  32'(head[10:8]));
      chk({tag, ".ts"},       32'(ev_if.ev_ts),    32'(head[7:0]));
      chk({tag, ".overflow"}, 32'(overflow),       32'(m_ovf));
      chk({tag, ".drop_cnt"}, 32'(drop_cnt),       32'(exp_dc));
   endtask

   // driver task: one clock with model update and output check
   task automatic tick(string tag);
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_outputs(tag);
   endtask

   task automatic ticks(string tag, int n);
      for (int i = 0; i < n; i++) tick(tag);
   endtask

   int         seen;
   logic [2:0] got_q[$];
   logic [2:0] order3 [3] = '{3'd1, 3'd3, 3'd6};
   logic [2:0] order6 [6] = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7};

   initial begin
      vectors = 0; miscompares = 0;
      pin0 = '0; pin1 = '0; pin2 = '0;
      m_pend = '0; m_ts = '0; m_ovf = 1'b0; m_drops = 0;
      rst_n = 1'b0; ena = 1'b1; ev_in = '0; ready = 1'b0;
      @(negedge clk);

      // reset state
      ticks("reset", 2);
      chk("reset.valid", 32'(ev_if.ev_valid), 32'd0);
      rst_n = 1'b1;

      // single pulse on channel 5, drained immediately
      ready = 1'b1;
      ev_in[5] = 1'b1;
      seen = 0;
      for (int i = 0; i < 3; i++) begin
         tick("pulse");
         if (ev_if.ev_valid) seen++;
      end
      ev_in[5] = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick("pulse");
         if (ev_if.ev_valid) begin
            seen++;
            chk("pulse.chan5", 32'(ev_if.ev_chan), 32'd5);
         end
      end
      chk("pulse.valid_cycles", 32'(seen), 32'd1);

      // simultaneous edges on 1, 3, 6 queue in index order
      ready = 1'b0;
      ev_in = 8'b0100_1010;
      ticks("simul", 6);
      ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         chk("simul.order", 32'(ev_if.ev_chan), 32'(order3[k]));
         tick("simul");
      end
      ev_in = '0;
      ticks("simul", 3);

      // six edges with a four-deep FIFO: four queued, two wait in pending
      ready = 1'b0;
      ev_in = 8'b1011_1101;
      ticks("full", 8);
      chk("full.valid", 32'(ev_if.ev_valid), 32'd1);
      chk("full.overflow", 32'(overflow), 32'd0);
      ready = 1'b1;
      got_q.delete();
      for (int i = 0; i < 10; i++) begin
         if (ev_if.ev_valid) got_q.push_back(ev_if.ev_chan);
         tick("full");
      end
      chk("full.delivered", 32'(got_q.size()), 32'd6);
      for (int k = 0; k < 6 && k < got_q.size(); k++)
         chk("full.order", 32'(got_q[k]), 32'(order6[k]));
      ev_in = '0;
      ticks("full", 3);

      // drops on channel 2 while it is pending behind a full FIFO
      ready = 1'b0;
      ev_in = 8'b0011_1011;
      ticks("drop", 10);
      ev_in[2] = 1'b1;
      ticks("drop", 4);
      ev_in[2] = 1'b0;
      tick("drop");
      ev_in[2] = 1'b1;
      ticks("drop", 4);
      chk("drop.overflow", 32'(overflow), 32'd1);
      chk("drop.one", 32'(drop_cnt), 32'(CNT_ON));
      for (int i = 0; i < 300; i++) begin
         ev_in[2] = 1'b0;
         tick("drop");
         ev_in[2] = 1'b1;
         tick("drop");
      end
      ticks("drop", 3);
      chk("drop.saturate", 32'(drop_cnt), CNT_ON ? 32'd255 : 32'd0);
      ready = 1'b1;
      ev_in = '0;
      ticks("drop", 12);

      // pin held high through reset release gives exactly one event
      ev_in = 8'h01;
      rst_n = 1'b0;
      ticks("hold", 2);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         tick("hold");
         if (ev_if.ev_valid) begin
            seen++;
            chk("hold.chan0", 32'(ev_if.ev_chan), 32'd0);
         end
      end
      chk("hold.count", 32'(seen), 32'd1);

      // reset with three queued events discards them all
      ready = 1'b0;
      ev_in = 8'b0000_1111;
      ticks("midrst", 7);
      chk("midrst.before", 32'(ev_if.ev_valid), 32'd1);
      ev_in = '0;
      rst_n = 1'b0;
      tick("midrst");
      chk("midrst.cleared", 32'(ev_if.ev_valid), 32'd0);
      rst_n = 1'b1;
      ready = 1'b1;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         tick("midrst");
         if (ev_if.ev_valid) seen++;
      end
      chk("midrst.stale", 32'(seen), 32'd0);

      // full FIFO draining with a push and pop every cycle across ts wrap
      ready = 1'b0;
      ev_in = 8'hff;
      ticks("stream", 8);
      ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         ev_in = ~ev_in;
         tick("stream");
         chk("stream.valid", 32'(ev_if.ev_valid), 32'd1);
      end
      ev_in = '0;
      ticks("stream", 20);

      // randomized pins, ready, ena and occasional reset
      for (int i = 0; i < 1500; i++) begin
         for (int b = 0; b < 8; b++)
            if ($urandom_range(0, 3) == 0) ev_in[b] = ~ev_in[b];
         ready = ($urandom_range(0, 3) != 0);
         ena   = ($urandom_range(0, 15) != 0);
         rst_n = ($urandom_range(0, 199) != 0);
         tick("random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
